// File: rtl/seg7_pkg.sv
// Shared segment encodings and types for the multiplexed 7-segment capture path.
package seg7_pkg;

   // Segment lines a..g, index 0 = a, active-low.
   typedef logic [0:6] seg_code_t;

   localparam seg_code_t SEG_CODE_0 = 7'b0000001;
   localparam seg_code_t SEG_CODE_1 = 7'b1001111;
   localparam seg_code_t SEG_CODE_2 = 7'b0010010;
   localparam seg_code_t SEG_CODE_3 = 7'b0000110;
   localparam seg_code_t SEG_CODE_4 = 7'b1001100;
   localparam seg_code_t SEG_CODE_5 = 7'b0100100;
   localparam seg_code_t SEG_CODE_6 = 7'b0100000;
   localparam seg_code_t SEG_CODE_7 = 7'b0001111;
   localparam seg_code_t SEG_CODE_8 = 7'b0000000;
   localparam seg_code_t SEG_CODE_9 = 7'b0000100;

   localparam logic [3:0] BLANK_DIGIT = 4'b1111;
   localparam logic [3:0] BAD_BCD     = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } cap_state_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Scan-line inputs and captured-frame outputs of the 7-segment capture block.
interface seg7_capture_if;
   import seg7_pkg::*;

   seg_code_t  seg;
   logic [3:0] digit;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [3:0] hundreds;
   logic [3:0] thousands;
   logic       frame_valid;
   logic       pattern_err;
   logic       strobe_err;
   logic       stale;
   cap_state_t dbg_state;

   // frame_valid is a one-cycle pulse with no ready: the four digits and
   // pattern_err change only on that cycle and hold until the next pulse.
   modport master (
      output seg, digit,
      input  ones, tens, hundreds, thousands,
      input  frame_valid, pattern_err, strobe_err, stale, dbg_state
   );

   modport slave (
      input  seg, digit,
      output ones, tens, hundreds, thousands,
      output frame_valid, pattern_err, strobe_err, stale, dbg_state
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational active-low segment pattern to BCD decoder; unknown patterns flag bad.
module seg7_decode
   import seg7_pkg::*;
(
   input  seg_code_t  seg,
   output logic [3:0] bcd,
   output logic       bad
);

   always_comb begin
      bcd = BAD_BCD;
      bad = 1'b0;
      case (seg)
         SEG_CODE_0: bcd = 4'd0;
         SEG_CODE_1: bcd = 4'd1;
         SEG_CODE_2: bcd = 4'd2;
         SEG_CODE_3: bcd = 4'd3;
         SEG_CODE_4: bcd = 4'd4;
         SEG_CODE_5: bcd = 4'd5;
         SEG_CODE_6: bcd = 4'd6;
         SEG_CODE_7: bcd = 4'd7;
         SEG_CODE_8: bcd = 4'd8;
         SEG_CODE_9: bcd = 4'd9;
         default: begin
            bcd = BAD_BCD;
            bad = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Samples a scanned 4-digit 7-segment display, settles each strobe, decodes it
// and reassembles the four digits into frames with error and staleness status.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic           clk_100MHz,
   input  logic           reset,
   seg7_capture_if.slave  bus
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   seg_code_t  seg_s1, seg_s2;
   logic [3:0] dig_s1, dig_s2;

   // Synchronisers clear to the idle (all-high) line level so release looks blank.
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         seg_s1 <= 7'h7F;
         seg_s2 <= 7'h7F;
         dig_s1 <= BLANK_DIGIT;
         dig_s2 <= BLANK_DIGIT;
      end else begin
         seg_s1 <= bus.seg;
         seg_s2 <= seg_s1;
         dig_s1 <= bus.digit;
         dig_s2 <= dig_s1;
      end
   end

   logic [2:0] low_cnt;
   logic [1:0] strobe_idx;
   logic       strobe_ok, strobe_bad;

   always_comb begin
      low_cnt    = '0;
      strobe_idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (!dig_s2[i]) begin
            low_cnt    = low_cnt + 3'd1;
            strobe_idx = 2'(i);
         end
      end
      strobe_ok  = (low_cnt == 3'd1);
      strobe_bad = (low_cnt > 3'd1);
   end

   cap_state_t state, state_nxt;
   logic [3:0] snap_dig, snap_dig_nxt;
   seg_code_t  snap_seg, snap_seg_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic       capture, restart, same;

   // A sample that breaks SETTLE or HELD is re-evaluated as an IDLE input.
   always_comb begin
      state_nxt    = state;
      snap_dig_nxt = snap_dig;
      snap_seg_nxt = snap_seg;
      cnt_nxt      = cnt;
      capture      = 1'b0;
      restart      = 1'b0;
      same         = (dig_s2 == snap_dig) && (seg_s2 == snap_seg);
      case (state)
         ST_SETTLE: begin
            if (same) begin
               cnt_nxt = cnt + CW'(1);
               if (cnt_nxt == CW'(SETTLE_CYCLES)) begin
                  capture   = 1'b1;
                  state_nxt = ST_HELD;
               end
            end else begin
               restart = 1'b1;
            end
         end
         ST_HELD:  restart = !same;
         default:  restart = 1'b1;
      endcase
      if (restart) begin
         if (strobe_ok) begin
            state_nxt    = ST_SETTLE;
            snap_dig_nxt = dig_s2;
            snap_seg_nxt = seg_s2;
            cnt_nxt      = CW'(1);
         end else begin
            state_nxt = ST_IDLE;
         end
      end
   end

   logic [3:0] dec_bcd;
   logic       dec_bad;

   seg7_decode u_decode (
      .seg (seg_s2),
      .bcd (dec_bcd),
      .bad (dec_bad)
   );

   logic [3:0][3:0] shadow_bcd, shadow_bcd_nxt;
   logic [3:0]      shadow_bad, shadow_bad_nxt;
   logic [3:0]      seen, seen_nxt;
   logic            complete;

   // Completion is taken at the same edge as the fourth capture, so the
   // frame appears one cycle after it and seen is already clear for the next.
   always_comb begin
      shadow_bcd_nxt = shadow_bcd;
      shadow_bad_nxt = shadow_bad;
      seen_nxt       = seen;
      if (capture) begin
         shadow_bcd_nxt[strobe_idx] = dec_bcd;
         shadow_bad_nxt[strobe_idx] = dec_bad;
         seen_nxt[strobe_idx]       = 1'b1;
      end
      complete = (seen_nxt == 4'b1111);
   end

   logic [3:0][3:0] frame_q;
   logic            frame_valid_q, pattern_err_q, strobe_err_q, illegal_q;
   logic [TW-1:0]   tcnt;

   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         snap_dig      <= BLANK_DIGIT;
         snap_seg      <= 7'h7F;
         cnt           <= '0;
         shadow_bcd    <= '0;
         shadow_bad    <= '0;
         seen          <= '0;
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
         pattern_err_q <= 1'b0;
         strobe_err_q  <= 1'b0;
         illegal_q     <= 1'b0;
         tcnt          <= '0;
      end else begin
         state         <= state_nxt;
         snap_dig      <= snap_dig_nxt;
         snap_seg      <= snap_seg_nxt;
         cnt           <= cnt_nxt;
         shadow_bcd    <= shadow_bcd_nxt;
         shadow_bad    <= shadow_bad_nxt;
         seen          <= complete ? 4'b0000 : seen_nxt;
         frame_valid_q <= complete;
         if (complete) begin
            frame_q       <= shadow_bcd_nxt;
            pattern_err_q <= |shadow_bad_nxt;
         end
         illegal_q    <= strobe_bad;
         strobe_err_q <= strobe_bad && !illegal_q;
         if (complete)
            tcnt <= '0;
         else if (tcnt != TW'(TIMEOUT_CYCLES))
            tcnt <= tcnt + TW'(1);
      end
   end

   assign bus.ones        = frame_q[0];
   assign bus.tens        = frame_q[1];
   assign bus.hundreds    = frame_q[2];
   assign bus.thousands   = frame_q[3];
   assign bus.frame_valid = frame_valid_q;
   assign bus.pattern_err = pattern_err_q;
   assign bus.strobe_err  = strobe_err_q;
   assign bus.stale       = (tcnt == TW'(TIMEOUT_CYCLES));
   assign bus.dbg_state   = state;

endmodule

// File: tb/tb_seg7_capture.sv
// Randomised and directed bench for seg7_capture against a run-length reference model.
module tb_seg7_capture;
  import seg7_pkg::*;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 5000;
  localparam logic [6:0] CODE_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
    7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // clock / reset
  logic clk_100MHz = 1'b0;
  logic reset      = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  seg7_capture_if bus();

  seg7_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: the input stream as runs of identical (digit, seg) samples
  logic [3:0]  run_dig;
  logic [6:0]  run_seg;
  int          run_len;
  bit          run_illegal;
  logic [3:0]  m_bcd [4];
  logic [3:0]  m_bad;
  logic [3:0]  m_seen;
  int          exp_strobe = 0;
  int          exp_frames = 0;
  logic [16:0] exp_q [$];

  function automatic int lows(input logic [3:0] d);
    return 4 - $countones(d);
  endfunction

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int v = 0; v < 10; v++)
      if (s == CODE_TAB[v]) return {1'b0, 4'(v)};
    return {1'b1, 4'hF};
  endfunction

  task automatic model_reset();
    run_dig     = 4'hF;
    run_seg     = 7'h7F;
    run_len     = 0;
    run_illegal = 1'b0;
    m_seen      = 4'h0;
  endtask

  task automatic model_apply(input logic [3:0] d, input logic [6:0] s, input int len);
    int old_len;
    int idx;
    logic [4:0] dec;
    if (d == run_dig && s == run_seg) begin
      old_len = run_len;
    end else begin
      if (lows(d) > 1 && !run_illegal) exp_strobe++;
      run_illegal = (lows(d) > 1);
      run_dig     = d;
      run_seg     = s;
      old_len     = 0;
    end
    run_len = old_len + len;
    if (lows(d) == 1 && old_len < SETTLE && run_len >= SETTLE) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!d[i]) idx = i;
      dec         = ref_decode(s);
      m_bcd[idx]  = dec[3:0];
      m_bad[idx]  = dec[4];
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        exp_q.push_back({|m_bad, m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]});
        exp_frames++;
        m_seen = 4'h0;
      end
    end
  endtask

  // driver tasks: inputs change just after the rising edge
  task automatic drive(input logic [3:0] d, input logic [6:0] s, input int len);
    model_apply(d, s, len);
    bus.digit = d;
    bus.seg   = s;
    repeat (len) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic drive_digit(input int idx, input logic [6:0] code, input int len);
    logic [3:0] d;
    d = 4'hF;
    d[idx] = 1'b0;
    drive(d, code, len);
  endtask

  task automatic scan(input int th, input int hu, input int te, input int on, input int len);
    drive_digit(0, CODE_TAB[on], len);
    drive_digit(1, CODE_TAB[te], len);
    drive_digit(2, CODE_TAB[hu], len);
    drive_digit(3, CODE_TAB[th], len);
  endtask

  task automatic blank(input int len);
    drive(4'hF, 7'h7F, len);
  endtask

  // scoreboard / monitor on the falling edge
  int neg_cyc    = 0;
  int ref_cyc    = 0;
  bit had_frame  = 1'b0;
  int obs_frames = 0;
  int obs_strobe = 0;
  bit prev_strobe, prev_stale;

  always @(negedge clk_100MHz) begin
    neg_cyc++;
    if (!reset) begin
      had_frame   = 1'b0;
      prev_strobe = 1'b0;
      prev_stale  = 1'b0;
    end else begin
      if (bus.frame_valid) begin
        obs_frames++;
        check("stale_on_frame", bus.stale, 0);
        check("frame_queued", exp_q.size() > 0, 1);
        if (exp_q.size() > 0)
          check("frame", {bus.pattern_err, bus.thousands, bus.hundreds, bus.tens, bus.ones},
                exp_q.pop_front());
        ref_cyc   = neg_cyc;
        had_frame = 1'b1;
      end
      if (bus.strobe_err) begin
        obs_strobe++;
        check("strobe_err_width", prev_strobe, 0);
      end
      if (bus.stale && !prev_stale && had_frame)
        check("stale_delay", neg_cyc - ref_cyc, TIMEOUT);
      prev_strobe = bus.strobe_err;
      prev_stale  = bus.stale;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int f0, s0, lat;
    logic [3:0] d;
    bus.digit = 4'hF;
    bus.seg   = 7'h7F;
    model_reset();
    repeat (3) @(posedge clk_100MHz);
    #1;
    check("reset_outputs", {bus.ones, bus.tens, bus.hundreds, bus.thousands,
          bus.frame_valid, bus.pattern_err, bus.strobe_err, bus.stale}, 0);
    reset = 1'b1;
    blank(5);

    // clean scan: 3,0,2,5 for two rotations
    f0 = obs_frames;
    scan(3, 0, 2, 5, 1000);
    scan(3, 0, 2, 5, 1000);
    blank(10);
    check("clean_frames", obs_frames - f0, 2);
    check("clean_value", {bus.pattern_err, bus.thousands, bus.hundreds, bus.tens, bus.ones},
          17'h03025);

    // fourth capture latency from input change
    drive_digit(0, CODE_TAB[1], 100);
    drive_digit(1, CODE_TAB[2], 100);
    drive_digit(2, CODE_TAB[3], 100);
    model_apply(4'b0111, CODE_TAB[4], 60);
    bus.digit = 4'b0111;
    bus.seg   = CODE_TAB[4];
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_100MHz);
      #1;
      if (bus.frame_valid && lat == 0) lat = i;
    end
    check("frame_latency", lat, SETTLE + 2);

    // glitch rejection: short 7 then settled 8 on ones
    drive_digit(0, CODE_TAB[7], 10);
    drive_digit(0, CODE_TAB[8], 1000);
    drive_digit(1, CODE_TAB[6], 200);
    drive_digit(2, CODE_TAB[4], 200);
    drive_digit(3, CODE_TAB[9], 200);
    blank(10);
    check("glitch_ones", bus.ones, 8);

    // undecodable tens pattern, then a clean scan clears the error
    drive_digit(0, CODE_TAB[5], 200);
    drive_digit(1, 7'h7F, 200);
    drive_digit(2, CODE_TAB[1], 200);
    drive_digit(3, CODE_TAB[2], 200);
    blank(10);
    check("bad_tens", bus.tens, 4'hF);
    check("bad_pattern_err", bus.pattern_err, 1);
    scan(1, 2, 3, 4, 200);
    blank(10);
    check("clean_pattern_err", bus.pattern_err, 0);

    // held illegal strobe pulses once and captures nothing
    s0 = obs_strobe;
    f0 = obs_frames;
    drive(4'b1100, CODE_TAB[3], 50);
    blank(5);
    check("illegal_pulses", obs_strobe - s0, 1);
    check("illegal_no_frame", obs_frames - f0, 0);

    // timeout: no scan, then resume
    blank(TIMEOUT + 20);
    check("stale_high", bus.stale, 1);
    scan(9, 8, 7, 6, 100);
    blank(5);
    check("stale_cleared", bus.stale, 0);

    // async reset after two captures
    drive_digit(0, CODE_TAB[2], 100);
    drive_digit(1, CODE_TAB[7], 100);
    blank(5);
    check("drained_before_reset", exp_q.size(), 0);
    reset = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #1;
    check("midframe_reset_outputs", {bus.ones, bus.tens, bus.hundreds, bus.thousands,
          bus.frame_valid, bus.pattern_err, bus.strobe_err, bus.stale}, 0);
    model_reset();
    reset = 1'b1;
    blank(5);
    f0 = obs_frames;
    drive_digit(2, CODE_TAB[5], 100);
    drive_digit(3, CODE_TAB[1], 100);
    check("partial_no_frame", obs_frames - f0, 0);
    check("partial_outputs_zero", {bus.thousands, bus.hundreds, bus.tens, bus.ones}, 0);
    drive_digit(0, CODE_TAB[9], 100);
    drive_digit(1, CODE_TAB[0], 100);
    blank(5);
    check("post_reset_frame", obs_frames - f0, 1);

    // randomised scans with glitches, gaps, bad patterns and illegal strobes
    for (int r = 0; r < 30; r++) begin
      for (int idx = 0; idx < 4; idx++) begin
        int kind;
        logic [6:0] code;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          d = 4'($urandom_range(0, 15)) & (($urandom_range(0, 1) == 1) ? 4'b1100 : 4'b0101);
          drive(d, 7'($urandom), $urandom_range(1, 8));
        end else if (kind == 1) begin
          blank($urandom_range(1, 4));
        end else if (kind <= 3) begin
          drive_digit(idx, CODE_TAB[$urandom_range(0, 9)], $urandom_range(10, 17));
        end
        code = (kind == 9) ? 7'($urandom) : CODE_TAB[$urandom_range(0, 9)];
        drive_digit(idx, code, $urandom_range(16, 120));
      end
    end
    blank(30);

    check("frames_total", obs_frames, exp_frames);
    check("strobe_total", obs_strobe, exp_strobe);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
